// File: rtl/core_pkg.sv
// core_pkg: shared constants and fetch FSM state type for the core.
package core_pkg;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP = 32'd4;
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, IDLE = 2'd2} fetch_state_t;
endpackage

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: holds the PC, drives imem, and fills the IF/ID register with valid/ready, redirect and fetch gating.
module pc_fetch_stage
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = core_pkg::RESET_VECTOR_DEFAULT,
   parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        id_ready,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        misalign_err
);
   fetch_state_t state_q, state_d;
   logic [31:0] pc_q, pc_d, ipc_q, ipc_d, instr_q, instr_d, plus4_q, plus4_d;
   logic valid_q, valid_d, mis_q, mis_d, stall, fetch;
   assign stall = valid_q & ~id_ready;
   assign fetch = (state_q == RUN) & fetch_en & ~stall;
   always_comb begin
      state_d = state_q;
      pc_d = pc_q;
      ipc_d = ipc_q;
      instr_d = instr_q;
      plus4_d = plus4_q;
      valid_d = valid_q;
      mis_d = 1'b0;
      if (redirect) begin
         pc_d = {redirect_target[31:2], 2'b00};
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         mis_d = |redirect_target[1:0];
         state_d = (state_q == BOOT) ? RUN : state_q;
      end else begin
         state_d = (state_q == BOOT) ? RUN :
                   (state_q == RUN && !fetch_en) ? IDLE :
                   (state_q == IDLE && fetch_en) ? RUN : state_q;
         if (fetch) begin
            ipc_d = pc_q;
            instr_d = imem_rdata;
            plus4_d = pc_q + PC_STEP;
            valid_d = 1'b1;
            pc_d = pc_q + PC_STEP;
         end else if (!stall && id_ready) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q <= RESET_VECTOR;
         ipc_q <= '0;
         instr_q <= NOP_INSTR;
         plus4_q <= '0;
         valid_q <= 1'b0;
         mis_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         ipc_q <= ipc_d;
         instr_q <= instr_d;
         plus4_q <= plus4_d;
         valid_q <= valid_d;
         mis_q <= mis_d;
      end
   end
   assign imem_addr = pc_q;
   assign if_id_valid = valid_q;
   assign if_id_pc = ipc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc_plus4 = plus4_q;
   assign misalign_err = mis_q;
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed and random stimulus against a behavioural fetch-stage model.
module tb_pc_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_0000;
   logic clk = 1'b0, rst = 1'b1, fetch_en = 1'b0, redirect = 1'b0, id_ready = 1'b0;
   logic [31:0] redirect_target = '0, imem_addr, imem_rdata, if_id_pc, if_id_instr, if_id_pc_plus4;
   logic if_id_valid, misalign_err;
   int tests = 0, fails = 0;
   // model state: booting/idle flags describe which of the three modes the stage is in
   logic [31:0] m_pc, m_ipc, m_ins, m_p4;
   logic m_v, m_mis, m_boot, m_idle;
   wire [129:0] dut_v = {if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4, misalign_err, imem_addr};
   wire [129:0] mdl_v = {m_v, m_ipc, m_ins, m_p4, m_mis, m_pc};

   pc_fetch_stage dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect(redirect),
      .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .id_ready(id_ready), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
      .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .misalign_err(misalign_err)
   );

   assign imem_rdata = imem_addr ^ KEY;
   always #5 clk = ~clk;

   task automatic step(input bit r, input bit fe, input bit rd, input bit rdy, input logic [31:0] tg);
      bit stall;
      rst = r; fetch_en = fe; redirect = rd; id_ready = rdy; redirect_target = tg;
      if (r) begin
         m_pc = 32'h0; m_boot = 1; m_idle = 0; m_v = 0; m_ipc = 0; m_ins = NOP; m_p4 = 0; m_mis = 0;
      end else begin
         stall = m_v && !rdy;
         if (rd) begin
            m_pc = tg & 32'hFFFF_FFFC; m_v = 0; m_ins = NOP; m_mis = (tg[1:0] != 2'b00); m_boot = 0;
         end else begin
            m_mis = 0;
            if (!m_boot && !m_idle && fe && !stall) begin
               m_ipc = m_pc; m_ins = m_pc ^ KEY; m_p4 = m_pc + 32'd4; m_v = 1; m_pc = m_pc + 32'd4;
            end else if (!stall && rdy) begin
               m_v = 0; m_ins = NOP;
            end
            if (m_boot) m_boot = 0;
            else if (!m_idle && !fe) m_idle = 1;
            else if (m_idle && fe) m_idle = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      step(1, 1, 0, 1, 0);
      step(1, 1, 0, 1, 0);
      tests++;
      if (dut_v !== {1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0}) begin
         fails++; $display("FAIL reset: got %h want %h", dut_v, mdl_v);
      end
   endtask

   task automatic test_fetch;
      step(0, 1, 0, 1, 0);
      tests++;
      if (if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin
         fails++; $display("FAIL boot_cycle: valid %b addr %h want 0/0", if_id_valid, imem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 1, 0);
         tests++;
         if (dut_v !== mdl_v || if_id_pc !== 32'(4 * i) || if_id_pc_plus4 !== 32'(4 * i + 4)) begin
            fails++; $display("FAIL fetch_%0d: got %h want %h", i, dut_v, mdl_v);
         end
      end
   endtask

   task automatic test_stall;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0, 0);
         tests++;
         if (dut_v !== mdl_v || if_id_pc !== 32'h8 || imem_addr !== 32'hC || !if_id_valid) begin
            fails++; $display("FAIL stall_%0d: got %h want %h", i, dut_v, mdl_v);
         end
      end
      step(0, 1, 0, 1, 0);
      tests++;
      if (dut_v !== mdl_v || if_id_pc !== 32'hC) begin
         fails++; $display("FAIL stall_release: got %h want %h", dut_v, mdl_v);
      end
   endtask

   task automatic test_redirect_stall;
      step(0, 1, 1, 0, 32'h100);
      tests++;
      if (dut_v !== mdl_v || if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr !== 32'h100) begin
         fails++; $display("FAIL redirect_flush: got %h want %h", dut_v, mdl_v);
      end
      step(0, 1, 0, 0, 0);
      tests++;
      if (dut_v !== mdl_v || if_id_pc !== 32'h100 || !if_id_valid) begin
         fails++; $display("FAIL redirect_fetch: got %h want %h", dut_v, mdl_v);
      end
   endtask

   task automatic test_misalign;
      step(0, 1, 1, 1, 32'h206);
      tests++;
      if (dut_v !== mdl_v || misalign_err !== 1'b1 || imem_addr !== 32'h204) begin
         fails++; $display("FAIL misalign_pulse: got %h want %h", dut_v, mdl_v);
      end
      step(0, 1, 0, 1, 0);
      tests++;
      if (dut_v !== mdl_v || misalign_err !== 1'b0) begin
         fails++; $display("FAIL misalign_clear: got %h want %h", dut_v, mdl_v);
      end
   endtask

   task automatic test_wrap;
      step(0, 1, 1, 1, 32'hFFFF_FFFC);
      step(0, 1, 0, 1, 0);
      tests++;
      if (dut_v !== mdl_v || if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin
         fails++; $display("FAIL wrap: got %h want %h", dut_v, mdl_v);
      end
   endtask

   task automatic test_gating;
      logic [31:0] frozen;
      step(0, 0, 0, 1, 0);
      frozen = imem_addr;
      tests++;
      if (dut_v !== mdl_v || if_id_valid !== 1'b0) begin
         fails++; $display("FAIL gate_drop: got %h want %h", dut_v, mdl_v);
      end
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      tests++;
      if (dut_v !== mdl_v || imem_addr !== frozen) begin
         fails++; $display("FAIL gate_freeze: got %h want %h", dut_v, mdl_v);
      end
      step(0, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
      tests++;
      if (dut_v !== mdl_v || if_id_pc !== frozen || !if_id_valid) begin
         fails++; $display("FAIL gate_resume: got %h want %h", dut_v, mdl_v);
      end
   endtask

   task automatic test_reset_redirect;
      step(0, 1, 1, 0, 32'h0000_0333);
      step(1, 1, 1, 0, 32'h0000_0777);
      tests++;
      if (dut_v !== {1'b0, 32'h0, NOP, 32'h0, 1'b0, 32'h0}) begin
         fails++; $display("FAIL reset_mid_redirect: got %h want %h", dut_v, mdl_v);
      end
      step(0, 1, 0, 1, 0);
      tests++;
      if (if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin
         fails++; $display("FAIL reset_boot: valid %b addr %h want 0/0", if_id_valid, imem_addr);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 3) != 0, $urandom);
         tests++;
         if (dut_v !== mdl_v) begin
            fails++; $display("FAIL random_%0d: got %h want %h", i, dut_v, mdl_v);
         end
      end
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_stall;
      test_redirect_stall;
      test_misalign;
      test_wrap;
      test_gating;
      test_reset_redirect;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
